bram_slave_mem: RTL and testbench
=================================

# bram_slave_mem

Synchronous single-port memory that terminates a `BramPort` at its Slave end. Masters such as the RAB configuration and miss-handling logic drive it exactly as they would a vendor Block RAM. It provides byte-wise writes and a configurable read latency of 1 or 2. It implements the `Rst_R` output-register reset, selectable write-collision behaviour, and a sticky out-of-range error flag. The block is the behavioural and ASIC-portable stand-in for FPGA BRAM primitives behind every `BramPort.Master` in the design.

## Interface
- DATA_BITW, 32, data width in bits; multiple of 8, at least 8.
- ADDR_BITW, 32, byte-address width.
- NUM_WORDS, 1024, memory depth in words; at least 2.
- RD_LAT, 1, read latency in cycles; only 1 or 2 allowed. Any other value is an elaboration error.
- WR_MODE, "READ_FIRST", one of "READ_FIRST", "WRITE_FIRST", "NO_CHANGE".

Ports:
- Clk_CI  input  1  single clock; all logic is rising-edge.
- Rst_RBI  input  1  asynchronous, active-low reset.
- Bram_PS  interface  BramPort.Slave  parameterized with DATA_BITW/ADDR_BITW.
  - Bram_PS.Clk_C is ignored; masters drive it from the Clk_CI source.
- OobErr_SO  output  1  sticky out-of-range access flag.
- OobClr_SI  input  1  synchronous clear of OobErr_SO.

## Operation
- **Word index:** Addr_S >> log2(DATA_BITW/8). The low byte-offset bits are ignored.
- **Access:** an access occurs on any rising edge with En_S=1.
  - WrEn_S≠0: write. Byte i of the word is replaced by Wr_D[8i+7:8i] when WrEn_S[i]=1; other bytes keep their value.
  - WrEn_S=0: read.
- **Read-data register (stage 1):**
  - Pure read: loads the addressed word.
  - Write, READ_FIRST: loads the pre-write word.
  - Write, WRITE_FIRST: loads the merged post-write word.
  - Write, NO_CHANGE: stage 1 holds.
  - En_S=0: stage 1 holds. Rd_D is stable between accesses.
- **Output stage 2 (RD_LAT=2 only):** loads stage 1 on every edge.
- **Rd_D source:** the last stage (stage 1 for RD_LAT=1, stage 2 for RD_LAT=2).
- **Rst_R (synchronous, active-high):** clears only the last stage to 0, independent of En_S.
  - It takes priority over a load of that stage in the same cycle.
  - A write in the same cycle still updates memory.
  - For RD_LAT=2, stage 1 loads normally.
- **Out of range (word index ≥ NUM_WORDS):**
  - Writes are dropped.
  - Reads load 0.
  - OobErr_SO is set on that edge.
- **OobErr_SO:**
  - Cleared by OobClr_SI=1.
  - Set has priority over clear in the same cycle.
- **Rst_RBI low:** stage registers and OobErr_SO go to 0 immediately. Memory contents are not reset (undefined after power-up).

## Timing
- Reset values: Rd_D=0, OobErr_SO=0.
- **RD_LAT=1:** access sampled at edge N; Rd_D shows the result after edge N (valid throughout cycle N+1).
- **RD_LAT=2:** the same result appears after edge N+1.
- **Writes:**
  - Visible to a read sampled on the next edge (N+1).
  - Back-to-back write/read to the same word returns the new data.
- **Throughput:** one access per cycle, no stalls, no backpressure.
- **Rst_R timing:** Rst_R at edge N gives Rd_D=0 after edge N.
  - RD_LAT=2 and a read at edge N−1: that read's data is lost.
  - RD_LAT=2 and a read at edge N: that read's data appears after edge N+1.
- **OobErr_SO timing:** asserts after the offending edge and stays until a clearing edge with no concurrent out-of-range access.
- **Asynchronous reset release:** first access is accepted on the first edge with Rst_RBI=1.

## Test plan
- **Byte-enable write, then read-back (RD_LAT=1, 32-bit):**
  - Stimulus: write 0xAABBCCDD to byte address 0x10 with WrEn=0xF; then WrEn=0x5 with Wr_D=0x11223344; then read 0x10.
  - Required: Rd_D=0xAA22CC44 one cycle after the read.
  - Also: a read of byte address 0x13 returns the same word.
- **Collision modes:**
  - Stimulus: word holds 0x1; write 0x2 to it with WrEn=0xF.
  - Required: Rd_D after that edge = 0x1 (READ_FIRST), 0x2 (WRITE_FIRST), or the previous Rd_D unchanged (NO_CHANGE).
- **RD_LAT=2 pipeline:**
  - Stimulus: back-to-back reads of words 0, 1, 2 holding 0xA, 0xB, 0xC.
  - Required: Rd_D=0xA, 0xB, 0xC on consecutive cycles, starting two edges after the first read; Rd_D holds 0xC while En_S=0.
- **Rst_R:**
  - Stimulus: after a read yields 0x5, assert Rst_R for one cycle with En_S=0.
  - Required: Rd_D=0.
  - Also: Rst_R together with a write of 0x7 still lets a later read return 0x7.
- **Out of range (NUM_WORDS=16, 32-bit):**
  - Stimulus: write 0xFFFFFFFF to byte address 0x40.
  - Required: word 0 is unchanged, OobErr_SO=1, and an out-of-range read returns 0.
  - Then: OobClr_SI with a concurrent out-of-range access keeps the flag at 1; OobClr_SI alone clears it to 0.
- **Asynchronous reset mid-operation:**
  - Stimulus: pull Rst_RBI low between edges while Rd_D=0x9 and OobErr_SO=1.
  - Required: both outputs read 0 immediately, with no clock edge needed.
  - Also: memory contents written before the reset are still readable after release.

Source files
------------

// File: rtl/bram_slave_mem_if.sv
// Block-RAM style port: one master drives address/data/enables, the slave returns read data.
interface BramPort #(
  parameter int unsigned DATA_BITW = 32,
  parameter int unsigned ADDR_BITW = 32
);
  logic                   Clk_C;
  logic                   Rst_R;
  logic                   En_S;
  logic [ADDR_BITW-1:0]   Addr_S;
  logic [DATA_BITW-1:0]   Rd_D;
  logic [DATA_BITW-1:0]   Wr_D;
  logic [DATA_BITW/8-1:0] WrEn_S;

  modport Master (
    output Clk_C, Rst_R, En_S, Addr_S, Wr_D, WrEn_S,
    input  Rd_D
  );

  modport Slave (
    input  Clk_C, Rst_R, En_S, Addr_S, Wr_D, WrEn_S,
    output Rd_D
  );
endinterface

// File: rtl/bram_slave_mem.sv
// Single-port byte-writable memory behind a BramPort slave, with 1- or 2-cycle read latency,
// selectable write-collision behaviour, output-register reset and a sticky out-of-range flag.
module bram_slave_mem #(
  parameter int unsigned DATA_BITW = 32,
  parameter int unsigned ADDR_BITW = 32,
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned RD_LAT    = 1,
  parameter string       WR_MODE   = "READ_FIRST"
) (
  input  logic   Clk_CI,
  input  logic   Rst_RBI,
  BramPort.Slave Bram_PS,
  output logic   OobErr_SO,
  input  logic   OobClr_SI
);

  localparam int unsigned NUM_BYTES = DATA_BITW / 8;
  localparam int unsigned OFF_W     = $clog2(NUM_BYTES);
  localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
  localparam logic [ADDR_BITW-1:0] NUM_WORDS_A = ADDR_BITW'(NUM_WORDS);
  localparam bit MODE_WF = (WR_MODE == "WRITE_FIRST");
  localparam bit MODE_NC = (WR_MODE == "NO_CHANGE");
  localparam bit MODE_RF = (WR_MODE == "READ_FIRST");

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("bram_slave_mem: RD_LAT must be 1 or 2");
  end
  if (!(MODE_WF || MODE_NC || MODE_RF)) begin : g_bad_mode
    $error("bram_slave_mem: WR_MODE must be READ_FIRST, WRITE_FIRST or NO_CHANGE");
  end
  if ((DATA_BITW % 8) != 0 || DATA_BITW < 8 || NUM_WORDS < 2) begin : g_bad_geom
    $error("bram_slave_mem: bad DATA_BITW or NUM_WORDS");
  end

  logic [DATA_BITW-1:0] mem [NUM_WORDS];

  logic [ADDR_BITW-1:0] word_idx;
  logic [IDX_W-1:0]     mem_idx;
  logic                 in_range;
  logic                 is_wr;
  logic [DATA_BITW-1:0] rd_word;
  logic [DATA_BITW-1:0] wr_word;
  logic [DATA_BITW-1:0] stage1_nxt;
  logic                 stage1_ld;
  logic [DATA_BITW-1:0] stage1_q;
  logic [DATA_BITW-1:0] rd_q;
  logic                 unused_clk;

  // Masters clock this port from the same source as Clk_CI, so the port clock is not used.
  assign unused_clk = Bram_PS.Clk_C;

  assign word_idx = Bram_PS.Addr_S >> OFF_W;
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign in_range = (word_idx < NUM_WORDS_A);
  assign is_wr    = |Bram_PS.WrEn_S;

  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = mem[mem_idx];
    wr_word = rd_word;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (Bram_PS.WrEn_S[i]) wr_word[8*i +: 8] = Bram_PS.Wr_D[8*i +: 8];
    end
  end

  always_comb begin
    stage1_nxt = rd_word;
    stage1_ld  = Bram_PS.En_S;
    if (is_wr) begin
      if (MODE_NC) stage1_ld = 1'b0;
      if (MODE_WF && in_range) stage1_nxt = wr_word;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Bram_PS.En_S && is_wr && in_range) mem[mem_idx] <= wr_word;
  end

  if (RD_LAT == 2) begin : g_lat2
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
        stage1_q <= '0;
        rd_q     <= '0;
      end else begin
        if (stage1_ld) stage1_q <= stage1_nxt;
        if (Bram_PS.Rst_R) rd_q <= '0;
        else               rd_q <= stage1_q;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI)           stage1_q <= '0;
      else if (Bram_PS.Rst_R) stage1_q <= '0;
      else if (stage1_ld)     stage1_q <= stage1_nxt;
    end
    assign rd_q = stage1_q;
  end

  assign Bram_PS.Rd_D = rd_q;

  // A new out-of-range access wins over a concurrent clear.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI)                       OobErr_SO <= 1'b0;
    else if (Bram_PS.En_S && !in_range) OobErr_SO <= 1'b1;
    else if (OobClr_SI)                 OobErr_SO <= 1'b0;
  end

endmodule

// File: tb/tb_bram_slave_mem.sv
// Directed bench for bram_slave_mem: four instances (READ_FIRST, WRITE_FIRST, NO_CHANGE at
// latency 1, READ_FIRST at latency 2), all 16 words deep, driven by one shared stimulus.
module tb_bram_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n, rst_r, en, oob_clr;
  logic [31:0] addr, wr_d;
  logic [3:0]  wr_en;
  logic [31:0] rd_rf, rd_wf, rd_nc, rd_l2;
  logic        oob_rf, oob_wf, oob_nc, oob_l2;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  BramPort #(.DATA_BITW(32), .ADDR_BITW(32)) bp_rf ();
  BramPort #(.DATA_BITW(32), .ADDR_BITW(32)) bp_wf ();
  BramPort #(.DATA_BITW(32), .ADDR_BITW(32)) bp_nc ();
  BramPort #(.DATA_BITW(32), .ADDR_BITW(32)) bp_l2 ();

  assign bp_rf.Clk_C = clk; assign bp_rf.Rst_R = rst_r; assign bp_rf.En_S = en;
  assign bp_rf.Addr_S = addr; assign bp_rf.Wr_D = wr_d; assign bp_rf.WrEn_S = wr_en;
  assign bp_wf.Clk_C = clk; assign bp_wf.Rst_R = rst_r; assign bp_wf.En_S = en;
  assign bp_wf.Addr_S = addr; assign bp_wf.Wr_D = wr_d; assign bp_wf.WrEn_S = wr_en;
  assign bp_nc.Clk_C = clk; assign bp_nc.Rst_R = rst_r; assign bp_nc.En_S = en;
  assign bp_nc.Addr_S = addr; assign bp_nc.Wr_D = wr_d; assign bp_nc.WrEn_S = wr_en;
  assign bp_l2.Clk_C = clk; assign bp_l2.Rst_R = rst_r; assign bp_l2.En_S = en;
  assign bp_l2.Addr_S = addr; assign bp_l2.Wr_D = wr_d; assign bp_l2.WrEn_S = wr_en;

  assign rd_rf = bp_rf.Rd_D;
  assign rd_wf = bp_wf.Rd_D;
  assign rd_nc = bp_nc.Rd_D;
  assign rd_l2 = bp_l2.Rd_D;

  bram_slave_mem #(.DATA_BITW(32), .ADDR_BITW(32), .NUM_WORDS(16), .RD_LAT(1), .WR_MODE("READ_FIRST"))
    u_rf (.Clk_CI(clk), .Rst_RBI(rst_n), .Bram_PS(bp_rf), .OobErr_SO(oob_rf), .OobClr_SI(oob_clr));
  bram_slave_mem #(.DATA_BITW(32), .ADDR_BITW(32), .NUM_WORDS(16), .RD_LAT(1), .WR_MODE("WRITE_FIRST"))
    u_wf (.Clk_CI(clk), .Rst_RBI(rst_n), .Bram_PS(bp_wf), .OobErr_SO(oob_wf), .OobClr_SI(oob_clr));
  bram_slave_mem #(.DATA_BITW(32), .ADDR_BITW(32), .NUM_WORDS(16), .RD_LAT(1), .WR_MODE("NO_CHANGE"))
    u_nc (.Clk_CI(clk), .Rst_RBI(rst_n), .Bram_PS(bp_nc), .OobErr_SO(oob_nc), .OobClr_SI(oob_clr));
  bram_slave_mem #(.DATA_BITW(32), .ADDR_BITW(32), .NUM_WORDS(16), .RD_LAT(2), .WR_MODE("READ_FIRST"))
    u_l2 (.Clk_CI(clk), .Rst_RBI(rst_n), .Bram_PS(bp_l2), .OobErr_SO(oob_l2), .OobClr_SI(oob_clr));

  // One access on the next edge; returns 1 time unit after that edge with the port idle.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    en = 1'b1; addr = a; wr_d = d; wr_en = we;
    @(posedge clk); #1;
    en = 1'b0; wr_en = 4'h0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_r = 1'b0; en = 1'b0; oob_clr = 1'b0;
    addr = '0; wr_d = '0; wr_en = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rd_rf !== 32'h0) $display("FAIL reset_rd_rf: got %h exp 0", rd_rf); else passed++;
    total++; if (rd_l2 !== 32'h0) $display("FAIL reset_rd_l2: got %h exp 0", rd_l2); else passed++;
    total++; if ({oob_rf, oob_wf, oob_nc, oob_l2} !== 4'b0)
      $display("FAIL reset_oob: got %b exp 0000", {oob_rf, oob_wf, oob_nc, oob_l2}); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_byte_enable();
    access(32'h10, 32'hAABBCCDD, 4'hF);
    access(32'h10, 32'h11223344, 4'h5);
    access(32'h10, 32'h0, 4'h0);
    total++; if (rd_rf !== 32'hAA22CC44) $display("FAIL be_rd_rf: got %h exp aa22cc44", rd_rf); else passed++;
    total++; if (rd_nc !== 32'hAA22CC44) $display("FAIL be_rd_nc: got %h exp aa22cc44", rd_nc); else passed++;
    idle();
    total++; if (rd_l2 !== 32'hAA22CC44) $display("FAIL be_rd_l2: got %h exp aa22cc44", rd_l2); else passed++;
    total++; if (rd_rf !== 32'hAA22CC44) $display("FAIL be_hold_rf: got %h exp aa22cc44", rd_rf); else passed++;
    access(32'h0C, 32'h0, 4'h0);
    access(32'h13, 32'h0, 4'h0);
    total++; if (rd_rf !== 32'hAA22CC44) $display("FAIL be_unaligned: got %h exp aa22cc44", rd_rf); else passed++;
  endtask

  task automatic test_collision();
    access(32'h14, 32'h1, 4'hF);
    access(32'h10, 32'h0, 4'h0);
    access(32'h14, 32'h2, 4'hF);
    total++; if (rd_rf !== 32'h1) $display("FAIL coll_read_first: got %h exp 1", rd_rf); else passed++;
    total++; if (rd_wf !== 32'h2) $display("FAIL coll_write_first: got %h exp 2", rd_wf); else passed++;
    total++; if (rd_nc !== 32'hAA22CC44) $display("FAIL coll_no_change: got %h exp aa22cc44", rd_nc); else passed++;
    access(32'h14, 32'h0, 4'h0);
    total++; if (rd_rf !== 32'h2) $display("FAIL coll_readback: got %h exp 2", rd_rf); else passed++;
  endtask

  task automatic test_back_to_back();
    access(32'h0, 32'hA, 4'hF);
    access(32'h4, 32'hB, 4'hF);
    access(32'h8, 32'hC, 4'hF);
    en = 1'b1; addr = 32'h0;
    @(posedge clk); #1;
    total++; if (rd_rf !== 32'hA) $display("FAIL b2b_lat1_first: got %h exp a", rd_rf); else passed++;
    addr = 32'h4;
    @(posedge clk); #1;
    total++; if (rd_l2 !== 32'hA) $display("FAIL b2b_lat2_a: got %h exp a", rd_l2); else passed++;
    addr = 32'h8;
    @(posedge clk); #1;
    total++; if (rd_l2 !== 32'hB) $display("FAIL b2b_lat2_b: got %h exp b", rd_l2); else passed++;
    en = 1'b0;
    @(posedge clk); #1;
    total++; if (rd_l2 !== 32'hC) $display("FAIL b2b_lat2_c: got %h exp c", rd_l2); else passed++;
    idle();
    total++; if (rd_l2 !== 32'hC) $display("FAIL b2b_lat2_hold: got %h exp c", rd_l2); else passed++;
  endtask

  task automatic test_rst_r();
    access(32'hC, 32'h5, 4'hF);
    access(32'hC, 32'h0, 4'h0);
    total++; if (rd_rf !== 32'h5) $display("FAIL rstr_pre_rf: got %h exp 5", rd_rf); else passed++;
    idle();
    total++; if (rd_l2 !== 32'h5) $display("FAIL rstr_pre_l2: got %h exp 5", rd_l2); else passed++;
    rst_r = 1'b1; idle(); rst_r = 1'b0;
    total++; if (rd_rf !== 32'h0) $display("FAIL rstr_clr_rf: got %h exp 0", rd_rf); else passed++;
    total++; if (rd_l2 !== 32'h0) $display("FAIL rstr_clr_l2: got %h exp 0", rd_l2); else passed++;
    rst_r = 1'b1; access(32'hC, 32'h7, 4'hF); rst_r = 1'b0;
    total++; if (rd_wf !== 32'h0) $display("FAIL rstr_wr_clr_wf: got %h exp 0", rd_wf); else passed++;
    access(32'hC, 32'h0, 4'h0);
    total++; if (rd_rf !== 32'h7) $display("FAIL rstr_wr_kept: got %h exp 7", rd_rf); else passed++;
    // Lat 2: read at the Rst_R edge survives into stage 2 one edge later.
    access(32'h10, 32'h0, 4'h0);
    rst_r = 1'b1; access(32'hC, 32'h0, 4'h0); rst_r = 1'b0;
    total++; if (rd_l2 !== 32'h0) $display("FAIL rstr_l2_lost: got %h exp 0", rd_l2); else passed++;
    idle();
    total++; if (rd_l2 !== 32'h7) $display("FAIL rstr_l2_same_edge: got %h exp 7", rd_l2); else passed++;
  endtask

  task automatic test_out_of_range();
    access(32'h40, 32'hFFFFFFFF, 4'hF);
    total++; if (oob_rf !== 1'b1) $display("FAIL oob_set_rf: got %b exp 1", oob_rf); else passed++;
    total++; if (oob_l2 !== 1'b1) $display("FAIL oob_set_l2: got %b exp 1", oob_l2); else passed++;
    access(32'h0, 32'h0, 4'h0);
    total++; if (rd_rf !== 32'hA) $display("FAIL oob_word0_kept: got %h exp a", rd_rf); else passed++;
    access(32'h40, 32'h0, 4'h0);
    total++; if (rd_rf !== 32'h0) $display("FAIL oob_read_zero: got %h exp 0", rd_rf); else passed++;
    oob_clr = 1'b1;
    access(32'h44, 32'h0, 4'h0);
    total++; if (oob_rf !== 1'b1) $display("FAIL oob_set_beats_clr: got %b exp 1", oob_rf); else passed++;
    idle();
    oob_clr = 1'b0;
    total++; if (oob_rf !== 1'b0) $display("FAIL oob_clear: got %b exp 0", oob_rf); else passed++;
    idle();
    total++; if (oob_rf !== 1'b0) $display("FAIL oob_stays_clear: got %b exp 0", oob_rf); else passed++;
  endtask

  task automatic test_async_reset();
    access(32'hC, 32'h9, 4'hF);
    access(32'h48, 32'h0, 4'h0);
    access(32'hC, 32'h0, 4'h0);
    total++; if (rd_rf !== 32'h9) $display("FAIL arst_pre_rd: got %h exp 9", rd_rf); else passed++;
    total++; if (oob_rf !== 1'b1) $display("FAIL arst_pre_oob: got %b exp 1", oob_rf); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (rd_rf !== 32'h0) $display("FAIL arst_rd_rf: got %h exp 0", rd_rf); else passed++;
    total++; if (rd_wf !== 32'h0) $display("FAIL arst_rd_wf: got %h exp 0", rd_wf); else passed++;
    total++; if (oob_rf !== 1'b0) $display("FAIL arst_oob: got %b exp 0", oob_rf); else passed++;
    #1 rst_n = 1'b1;
    access(32'hC, 32'h0, 4'h0);
    total++; if (rd_rf !== 32'h9) $display("FAIL arst_mem_kept: got %h exp 9", rd_rf); else passed++;
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_rst_r();
    test_out_of_range();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
